// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, operator codes and display constants for the calculator controller.
package calc_pkg;
  typedef enum logic [2:0] {S_OP1, S_OPSEL, S_OP2, S_EXEC, S_RESULT, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
  localparam logic [31:0] ERR_DISP = 32'hEEEE_EEEE;
endpackage

// File: rtl/operand_entry.sv
// operand_entry: next-value logic for shifting one BCD digit into an operand.
module operand_entry #(
  parameter int MAX_DIGITS = 8
) (
  input  logic [31:0] i_operand,
  input  logic [3:0]  i_count,
  input  logic [3:0]  i_digit,
  output logic [31:0] o_operand,
  output logic [3:0]  o_count,
  output logic        o_valid
);
  logic w_take;
  // A leading zero is a valid key but never occupies a digit slot.
  assign o_valid   = i_digit <= 4'd9;
  assign w_take    = o_valid && i_count < 4'(MAX_DIGITS) && !(i_digit == 4'd0 && i_count == 4'd0);
  assign o_operand = w_take ? {i_operand[27:0], i_digit} : i_operand;
  assign o_count   = w_take ? i_count + 4'd1 : i_count;
endmodule

// File: rtl/calc_control.sv
// calc_control: keypad sequencing FSM that builds BCD operands, launches the ALU and drives the display.
module calc_control
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 8,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        num_pressed,
  input  logic [3:0]  digit,
  input  logic        op_pressed,
  input  logic [1:0]  op_code,
  input  logic        eq_pressed,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_err,
  output logic [31:0] number1,
  output logic [31:0] number2,
  output logic [1:0]  op_q,
  output logic        alu_start,
  output logic [31:0] disp_value,
  output logic        refresh_digit,
  output logic [3:0]  digit_count,
  output logic [2:0]  state_o,
  output logic        error
);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  state_t        r_state;
  op_t           r_op;
  logic [31:0]   r_number1, r_number2, r_disp;
  logic [3:0]    r_count;
  logic [TW-1:0] r_timer;
  logic          r_alu_start, r_refresh, r_error;
  logic          w_eq, w_op, w_num, w_v1, w_v2;
  logic [31:0]   w_n1, w_n2, w_disp;
  logic [3:0]    w_c1, w_c2;
  assign w_eq  = eq_pressed;
  assign w_op  = op_pressed & ~eq_pressed;
  assign w_num = num_pressed & ~eq_pressed & ~op_pressed;
  assign w_disp = r_state == S_ERR ? ERR_DISP : r_state == S_OP2 ? r_number2 : r_number1;
  // A digit after a result starts a fresh number1; the first digit in OPSEL starts a fresh number2.
  operand_entry #(.MAX_DIGITS(MAX_DIGITS)) u_n1 (
    .i_operand (r_state == S_RESULT ? 32'd0 : r_number1),
    .i_count   (r_state == S_RESULT ? 4'd0 : r_count),
    .i_digit   (digit),
    .o_operand (w_n1),
    .o_count   (w_c1),
    .o_valid   (w_v1)
  );
  operand_entry #(.MAX_DIGITS(MAX_DIGITS)) u_n2 (
    .i_operand (r_state == S_OPSEL ? 32'd0 : r_number2),
    .i_count   (r_state == S_OPSEL ? 4'd0 : r_count),
    .i_digit   (digit),
    .o_operand (w_n2),
    .o_count   (w_c2),
    .o_valid   (w_v2)
  );
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= S_OP1;
      r_op        <= OP_ADD;
      r_number1   <= '0;
      r_number2   <= '0;
      r_disp      <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_alu_start <= 1'b0;
      r_refresh   <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_disp      <= w_disp;
      r_refresh   <= w_disp != r_disp;
      case (r_state)
        S_OP1: begin
          if (w_op) begin
            r_op    <= op_t'(op_code);
            r_count <= '0;
            r_state <= S_OPSEL;
          end else if (w_num) begin
            r_number1 <= w_n1;
            r_count   <= w_c1;
          end
        end
        S_OPSEL: begin
          if (w_op) r_op <= op_t'(op_code);
          else if (w_num && w_v2) begin
            r_number2 <= w_n2;
            r_count   <= w_c2;
            r_state   <= S_OP2;
          end
        end
        S_OP2: begin
          if (w_eq && r_count != 4'd0) begin
            r_alu_start <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_EXEC;
          end else if (w_num) begin
            r_number2 <= w_n2;
            r_count   <= w_c2;
          end
        end
        S_EXEC: begin
          if (alu_done && !alu_err) begin
            r_number1 <= alu_result;
            r_state   <= S_RESULT;
          end else if (alu_done || r_timer == TW'(ALU_TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_state <= S_ERR;
          end else r_timer <= r_timer + 1'b1;
        end
        S_RESULT: begin
          if (w_op) begin
            r_op    <= op_t'(op_code);
            r_count <= '0;
            r_state <= S_OPSEL;
          end else if (w_num && w_v1) begin
            r_number1 <= w_n1;
            r_number2 <= '0;
            r_count   <= w_c1;
            r_state   <= S_OP1;
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end
  assign number1       = r_number1;
  assign number2       = r_number2;
  assign op_q          = r_op;
  assign alu_start     = r_alu_start;
  assign disp_value    = r_disp;
  assign refresh_digit = r_refresh;
  assign digit_count   = r_count;
  assign state_o       = r_state;
  assign error         = r_error;
endmodule

// File: tb/tb_calc_control.sv
// tb_calc_control: directed keypad sequences with hand-computed expectations for calc_control.
module tb_calc_control;
  logic        clk = 0, clear = 0, num_pressed = 0, op_pressed = 0, eq_pressed = 0;
  logic        alu_done = 0, alu_err = 0;
  logic [3:0]  digit = 0;
  logic [1:0]  op_code = 0;
  logic [31:0] alu_result = 0;
  logic [31:0] number1, number2, disp_value;
  logic [1:0]  op_q;
  logic        alu_start, refresh_digit, error;
  logic [3:0]  digit_count;
  logic [2:0]  state_o;
  int          n_checks = 0, n_errors = 0, n_starts = 0;
  calc_control dut (
    .clk(clk), .clear(clear), .num_pressed(num_pressed), .digit(digit),
    .op_pressed(op_pressed), .op_code(op_code), .eq_pressed(eq_pressed),
    .alu_result(alu_result), .alu_done(alu_done), .alu_err(alu_err),
    .number1(number1), .number2(number2), .op_q(op_q), .alu_start(alu_start),
    .disp_value(disp_value), .refresh_digit(refresh_digit), .digit_count(digit_count),
    .state_o(state_o), .error(error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (alu_start) n_starts++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic rst();
    @(negedge clk); clear = 1;
    repeat (2) @(negedge clk);
    clear = 0;
  endtask
  task automatic num(input logic [3:0] d);
    @(negedge clk); num_pressed = 1; digit = d;
    @(negedge clk); num_pressed = 0;
  endtask
  task automatic op(input logic [1:0] c);
    @(negedge clk); op_pressed = 1; op_code = c;
    @(negedge clk); op_pressed = 0;
  endtask
  task automatic eq();
    @(negedge clk); eq_pressed = 1;
    @(negedge clk); eq_pressed = 0;
  endtask
  task automatic done(input logic [31:0] res, input logic err);
    @(negedge clk); alu_done = 1; alu_result = res; alu_err = err;
    @(negedge clk); alu_done = 0; alu_err = 0;
  endtask
  initial begin
    int c;
    rst();
    check("rst_state", state_o, 0);
    check("rst_n1", number1, 0);
    check("rst_n2", number2, 0);
    check("rst_disp", disp_value, 0);
    check("rst_flags", {alu_start, refresh_digit, error, op_q, digit_count}, 0);
    // 123 + 45 = with result 168 three cycles after equals
    num(1); num(2); num(3);
    check("op1_n1", number1, 32'h123);
    check("op1_cnt", digit_count, 3);
    op(2'b00);
    check("opsel_state", state_o, 1);
    num(4); num(5);
    check("op2_state", state_o, 2);
    check("op2_n2", number2, 32'h45);
    eq();
    check("exec_state", state_o, 3);
    check("exec_start", alu_start, 1);
    repeat (2) @(negedge clk);
    check("exec_start_gone", alu_start, 0);
    alu_done = 1; alu_result = 168;
    @(negedge clk); alu_done = 0;
    check("res_state", state_o, 4);
    check("res_n1", number1, 168);
    check("res_n2", number2, 32'h45);
    check("res_op", op_q, 0);
    check("res_starts", n_starts, 1);
    @(negedge clk);
    check("res_disp", disp_value, 168);
    check("res_refresh", refresh_digit, 1);
    @(negedge clk);
    check("res_refresh_pulse", refresh_digit, 0);
    // chain: - 7 =
    op(2'b01);
    check("chain_state", state_o, 1);
    check("chain_n1", number1, 168);
    num(7); eq();
    check("chain_n2", number2, 7);
    check("chain_op", op_q, 1);
    check("chain_exec", state_o, 3);
    done(161, 0);
    check("chain_res", number1, 161);
    check("chain_starts", n_starts, 2);
    // digit limits
    rst();
    num(0);
    check("lead0_cnt", digit_count, 0);
    num(4'hA);
    check("bad_digit_cnt", digit_count, 0);
    for (int i = 1; i <= 9; i++) num(4'(i));
    check("full_n1", number1, 32'h12345678);
    check("full_cnt", digit_count, 8);
    num(4'hA); num(0);
    check("full_hold", number1, 32'h12345678);
    // priority and ignored keys
    rst();
    num(5); eq();
    check("op1_eq_ignored", state_o, 0);
    @(negedge clk); num_pressed = 1; digit = 3; op_pressed = 1; op_code = 2'b10;
    @(negedge clk); num_pressed = 0; op_pressed = 0;
    check("prio_state", state_o, 1);
    check("prio_n1", number1, 5);
    check("prio_op", op_q, 2);
    num(0); eq();
    check("eq_cnt0_ignored", state_o, 2);
    // timeout to ERR
    rst();
    num(1); op(0); num(2); eq();
    c = 0;
    while (state_o == 3 && c < 400) begin c++; @(negedge clk); end
    check("to_cycles", c, 255);
    check("to_state", state_o, 5);
    check("to_error", error, 1);
    @(negedge clk);
    check("to_disp", disp_value, 32'hEEEEEEEE);
    num(3); op(1); eq(); done(9, 0);
    check("err_stuck", state_o, 5);
    check("err_disp_hold", disp_value, 32'hEEEEEEEE);
    rst();
    check("err_clear_state", state_o, 0);
    check("err_clear_err", error, 0);
    check("err_clear_disp", disp_value, 0);
    // clear during EXEC, then a stray alu_done
    num(1); op(3); num(2); eq();
    check("abort_exec", state_o, 3);
    rst();
    done(99, 0);
    check("abort_state", state_o, 0);
    check("abort_n1", number1, 0);
    check("abort_n2", number2, 0);
    check("abort_disp", disp_value, 0);
    check("abort_flags", {alu_start, refresh_digit, error, op_q, digit_count}, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/calc_control.md
CALC_CONTROL -- requirements
Module: calc_control

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8: maximum BCD digits per operand (4 bits each, packed LSD in [3:0]).
REQ-002 SHALL have parameter ALU_TIMEOUT, default 255: cycles to wait for alu_done before error.
REQ-003 SHALL have clk, input, 1: single rising-edge clock.
REQ-004 SHALL have clear, input, 1: synchronous, active-high reset.
REQ-005 SHALL have num_pressed, input, 1: one-cycle pulse, digit key accepted.
REQ-006 SHALL have digit, input, 4: BCD value qualified by num_pressed.
REQ-007 SHALL have op_pressed, input, 1: one-cycle pulse, operator key.
REQ-008 SHALL have op_code, input, 2: operator qualified by op_pressed (00 add, 01 sub, 10 mul, 11 div).
REQ-009 SHALL have eq_pressed, input, 1: one-cycle pulse, equals key.
REQ-010 SHALL have alu_result, input, 32: ALU result, valid with alu_done.
REQ-011 SHALL have alu_done / alu_err, input, 1 each: ALU completion pulse and error flag qualified by alu_done.
REQ-012 SHALL have number1 / number2, output, 32 each: operand registers driven to the ALU.
REQ-013 SHALL have op_q, output, 2: latched operator.
REQ-014 SHALL have alu_start, output, 1: one-cycle start pulse.
REQ-015 SHALL have disp_value, output, 32: value to display; refresh_digit, output, 1: one-cycle pulse whenever disp_value changes.
REQ-016 SHALL have digit_count, output, 4; state_o, output, 3; error, output, 1.

Function
REQ-017 States SHALL be OP1, OPSEL, OP2, EXEC, RESULT, ERR; state_o encodes them 0..5.
REQ-018 Event priority within one cycle SHALL be clear > eq_pressed > op_pressed > num_pressed; lower-priority pulses that cycle are dropped.
REQ-019 Digit entry (OP1 into number1, OP2 into number2): operand <= {operand[27:0], digit}, digit_count+1.
REQ-020 Digits with value > 9 SHALL be ignored in all states.
REQ-021 At digit_count == MAX_DIGITS further digits SHALL be ignored (no wrap, no shift).
REQ-022 A 0 digit while digit_count == 0 SHALL leave operand and count unchanged.
REQ-023 OP1: op_pressed -> op_q <= op_code, digit_count <= 0, go OPSEL; eq_pressed ignored.
REQ-024 OPSEL: op_pressed overwrites op_q; num_pressed enters first digit of number2 (number2 cleared first), go OP2; eq_pressed ignored.
REQ-025 OP2: eq_pressed with digit_count > 0 -> alu_start pulse next cycle, go EXEC; eq_pressed with count 0, and op_pressed, SHALL be ignored.
REQ-026 EXEC: all key pulses ignored; cycle counter counts from 0; alu_done with alu_err=0 -> number1 <= alu_result, go RESULT; alu_done with alu_err=1 or counter reaching ALU_TIMEOUT -> error <= 1, go ERR.
REQ-027 RESULT: op_pressed -> chain (number1 kept, op_q <= op_code, go OPSEL); num_pressed -> number1/number2 cleared, digit entered, go OP1; eq_pressed ignored.
REQ-028 ERR: all pulses except clear SHALL be ignored; disp_value = 32'hEEEE_EEEE.
REQ-029 disp_value SHALL be number2 in OP2, number1 in all other non-ERR states, registered.
REQ-030 refresh_digit SHALL assert exactly one cycle after the cycle in which disp_value's source register or selection changes.
REQ-031 alu_start SHALL never assert outside the OP2->EXEC transition; number1, number2, op_q SHALL be stable throughout EXEC.

Reset
REQ-032 On clear (sampled at clk edge): state OP1; number1, number2, disp_value 0; op_q 00; digit_count 0; alu_start, refresh_digit, error 0; timeout counter 0.
REQ-033 clear mid-EXEC SHALL abandon the operation; a later alu_done SHALL be ignored outside EXEC.

Structure
REQ-034 State encoding, op_code constants, and ERR display constant SHALL live in shared package calc_pkg.
REQ-035 Digit shift/count logic SHALL be one sub-module, operand_entry, instantiated twice (number1, number2).

Verification
REQ-036 Keys 1,2,3,+,4,5,= with alu_result 168 after 3 cycles -> number1=0x123, number2=0x45, op_q=00, one alu_start, RESULT, disp_value=168.
REQ-037 Nine digits 1..9 in OP1 -> number1=0x12345678, digit_count=8; digit 0xA ignored; leading 0 leaves count 0.
REQ-038 Same-cycle num_pressed and op_pressed in OP1 -> only op accepted, OPSEL, number1 unchanged.
REQ-039 alu_done never arrives -> ERR after 255 EXEC cycles, error=1, disp_value=0xEEEEEEEE; only clear recovers.
REQ-040 RESULT then '-' then 7 then '=' -> chained number1=prior result, number2=7, op_q=01.
REQ-041 clear asserted in EXEC, then alu_done pulse -> state OP1, all outputs reset values, number1 not updated.
